// File: rtl/mem_line_master_if.sv
// Wait-state memory port bundle: request, address and data out from the master,
// read data and ready/beat-valid back from the memory.
interface mem_line_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              MEnable;
  logic              MRead;
  logic              MWrite;
  logic [ADDR_W-1:0] MAddress;
  logic [DATA_W-1:0] MWriteData;
  logic [DATA_W-1:0] MReadData;
  logic              MReady;

  modport master (
    output MEnable, MRead, MWrite, MAddress, MWriteData,
    input  MReadData, MReady
  );

  modport slave (
    input  MEnable, MRead, MWrite, MAddress, MWriteData,
    output MReadData, MReady
  );
endinterface

// File: rtl/mem_line_master.sv
// Memory-port initiator: CPU reads become aligned line-fill bursts, writes become single stores.
// Optional RD_WAIT timeout with sticky err flag when MEM_MASTER_TIMEOUT_EN is defined.
module mem_line_master #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int BURST_LEN  = 16,
  parameter int WAIT_STATE = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cpu_read_i,
  input  logic                         cpu_write_i,
  input  logic [31:0]                  cpu_addr_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  output logic                         cpu_busy_o,
  output logic                         cpu_done_o,
  output logic                         line_wr_en_o,
  output logic [$clog2(BURST_LEN)-1:0] line_wr_idx_o,
  output logic [DATA_W-1:0]            line_wr_data_o,
  output logic                         err_o,
  mem_line_master_if.master            mem
);

  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int CNT_W = $clog2(TIMEOUT + WAIT_STATE + 2);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(BURST_LEN * 4 - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, RD_BURST, WR_REQ, WR_GAP, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               seen_low_q, seen_low_d;
  logic               wr_en_q, wr_en_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               accept;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^cpu_addr_i;

`ifdef MEM_MASTER_TIMEOUT_EN
  logic tmo_hit;
  logic err_q;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    seen_low_d = seen_low_q;
    wr_en_d    = 1'b0;
    rdata_d    = rdata_q;
    accept     = 1'b0;
`ifdef MEM_MASTER_TIMEOUT_EN
    tmo_hit    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (mem.MReady && cpu_read_i) begin
          accept  = 1'b1;
          state_d = RD_REQ;
        end else if (mem.MReady && cpu_write_i) begin
          accept  = 1'b1;
          state_d = WR_REQ;
        end
      end
      RD_REQ: begin
        seen_low_d = 1'b0;
        cnt_d      = '0;
        state_d    = RD_WAIT;
      end
      RD_WAIT: begin
        // Beat 0 is the first ready cycle after memory has dropped MReady.
        if (!mem.MReady) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          rdata_d = mem.MReadData;
          wr_en_d = 1'b1;
          idx_d   = '0;
          state_d = RD_BURST;
        end
`ifdef MEM_MASTER_TIMEOUT_EN
        cnt_d = cnt_q + CNT_W'(1);
        if (state_d == RD_WAIT && cnt_q == CNT_W'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
`endif
      end
      RD_BURST: begin
        rdata_d = mem.MReadData;
        wr_en_d = 1'b1;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(BURST_LEN - 2)) state_d = DONE;
      end
      WR_REQ: begin
        cnt_d   = '0;
        state_d = WR_GAP;
      end
      WR_GAP: begin
        if (cnt_q == CNT_W'(WAIT_STATE)) state_d = DONE;
        else                             cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      seen_low_q <= 1'b0;
      wr_en_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      seen_low_q <= seen_low_d;
      wr_en_q    <= wr_en_d;
      rdata_q    <= rdata_d;
    end
  end

  // Request payload is only driven while a request state gates it, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= cpu_addr_i[ADDR_W-1:0];
      wdata_q <= cpu_wdata_i;
    end
  end

`ifdef MEM_MASTER_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_q | tmo_hit;
  end
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign cpu_busy_o     = (state_q != IDLE);
  assign cpu_done_o     = (state_q == DONE);
  assign line_wr_en_o   = wr_en_q;
  assign line_wr_idx_o  = idx_q;
  assign line_wr_data_o = rdata_q;

  assign mem.MEnable    = (state_q == RD_REQ) || (state_q == WR_REQ);
  assign mem.MRead      = (state_q == RD_REQ);
  assign mem.MWrite     = (state_q == WR_REQ);
  assign mem.MAddress   = (state_q == RD_REQ) ? (addr_q & LINE_MASK) :
                          (state_q == WR_REQ) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem.MWriteData = (state_q == WR_REQ) ? wdata_q : '0;

endmodule

// File: tb/tb_mem_line_master.sv
// Directed bench for mem_line_master with a behavioural wait-state burst memory.
module tb_mem_line_master;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 16;
  localparam int BURST_LEN  = 16;
  localparam int WAIT_STATE = 2;
  localparam int TIMEOUT    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_busy, cpu_done, line_wr_en, err;
  logic [3:0]  line_wr_idx;
  logic [31:0] line_wr_data;

  always #5 clk = ~clk;

  mem_line_master_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) mem_if ();

  mem_line_master #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BURST_LEN),
    .WAIT_STATE(WAIT_STATE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_busy_o(cpu_busy), .cpu_done_o(cpu_done),
    .line_wr_en_o(line_wr_en), .line_wr_idx_o(line_wr_idx),
    .line_wr_data_o(line_wr_data), .err_o(err),
    .mem(mem_if)
  );

  // Memory model: drops MReady for WAIT_STATE cycles after a read, then streams the line.
  logic        mdl_ready = 1'b1;
  logic        tb_stall  = 1'b0;
  logic        mem_dead  = 1'b0;
  logic [31:0] mem [0:1023];
  int          base;

  assign mem_if.MReady = mdl_ready & ~tb_stall;

  initial begin : memory_model
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000 + i;
    for (int i = 0; i < 16; i++)   mem[64 + i] = 32'hA0 + i;
    mem_if.MReadData = '0;
    forever begin
      @(negedge clk);
      if (!mem_dead) mdl_ready = 1'b1;
      if (mem_if.MEnable && mem_if.MWrite) begin
        mem[mem_if.MAddress[11:2]] = mem_if.MWriteData;
      end else if (mem_if.MEnable && mem_if.MRead) begin
        base      = int'(mem_if.MAddress[11:2]);
        mdl_ready = 1'b0;
        if (!mem_dead) begin
          repeat (WAIT_STATE - 1) @(negedge clk);
          for (int b = 0; b < BURST_LEN; b++) begin
            @(negedge clk);
            mdl_ready        = 1'b1;
            mem_if.MReadData = mem[base + b];
          end
        end
      end
    end
  end

  // Observer of DUT outputs, sampled on the falling edge.
  int          cyc = 0, done_cnt = 0, wr_cnt = 0, men_cnt = 0, mrd_cnt = 0, mwr_cnt = 0;
  int          idx_err = 0, run = 0, done_cyc = 0, wreq_cyc = 0, rreq_cyc = 0;
  logic        prev_en = 1'b0;
  logic [31:0] cap [0:15];
  logic [15:0] last_raddr = '0, last_waddr = '0;
  logic [31:0] last_wdata = '0;

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (line_wr_en) begin
        if (!prev_en) run = 0;
        if (int'(line_wr_idx) != run) idx_err++;
        cap[line_wr_idx] = line_wr_data;
        run++;
        wr_cnt++;
      end
      prev_en = line_wr_en;
      if (cpu_done) begin done_cnt++; done_cyc = cyc; end
      if (mem_if.MEnable) men_cnt++;
      if (mem_if.MEnable && mem_if.MRead) begin
        mrd_cnt++; rreq_cyc = cyc; last_raddr = mem_if.MAddress;
      end
      if (mem_if.MEnable && mem_if.MWrite) begin
        mwr_cnt++; wreq_cyc = cyc; last_waddr = mem_if.MAddress; last_wdata = mem_if.MWriteData;
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cpu_read = rd; cpu_write = wr; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0, n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, " done pulses"}, 64'(done_cnt - d0), 64'd1);
  endtask

  int w0, w1, r0, m0, mw0, d0, e0, n;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    repeat (3) @(negedge clk);
    check("rst busy",    cpu_busy, 0);
    check("rst done",    cpu_done, 0);
    check("rst wr_en",   line_wr_en, 0);
    check("rst idx",     line_wr_idx, 0);
    check("rst data",    line_wr_data, 0);
    check("rst menable", mem_if.MEnable, 0);
    check("rst maddr",   mem_if.MAddress, 0);
    check("rst err",     err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Aligned line fill from 0x124
    w0 = wr_cnt; m0 = men_cnt; e0 = idx_err;
    issue(1'b1, 1'b0, 32'h0000_0124, 32'h0);
    wait_done("t1", 200);
    check("t1 maddr",      last_raddr, 16'h0100);
    check("t1 menable cy", 64'(men_cnt - m0), 64'd1);
    check("t1 beats",      64'(wr_cnt - w0), 64'd16);
    check("t1 idx seq",    64'(idx_err - e0), 64'd0);
    for (int k = 0; k < 16; k++) check($sformatf("t1 beat%0d", k), cap[k], 64'(32'hA0 + k));

    // Write then read back the same line
    issue(1'b0, 1'b1, 32'h0000_000A, 32'hDEAD_BEEF);
    wait_done("t2 wr", 50);
    check("t2 waddr",    last_waddr, 16'h0008);
    check("t2 wdata",    last_wdata, 32'hDEAD_BEEF);
    check("t2 done gap", 64'(done_cyc - wreq_cyc), 64'(WAIT_STATE + 2));
    issue(1'b1, 1'b0, 32'h0000_0004, 32'h0);
    wait_done("t2 rd", 200);
    check("t2 raddr", last_raddr, 16'h0000);
    check("t2 beat2", cap[2], 32'hDEAD_BEEF);
    check("t2 beat3", cap[3], 32'h0000_1003);

    // Read and write together, then a write while busy
    mw0 = mwr_cnt; r0 = mrd_cnt;
    issue(1'b1, 1'b1, 32'h0000_0124, 32'h1234_5678);
    repeat (3) @(negedge clk);
    check("t3 busy", cpu_busy, 1);
    cpu_write = 1'b1; cpu_addr = 32'h0000_0040;
    repeat (2) @(negedge clk);
    cpu_write = 1'b0;
    wait_done("t3", 200);
    check("t3 no mwrite", 64'(mwr_cnt - mw0), 64'd0);
    check("t3 one mread", 64'(mrd_cnt - r0), 64'd1);
    check("t3 beat9",     cap[9], 32'hA9);

    // Reset during beat 7
    d0 = done_cnt; w0 = wr_cnt;
    issue(1'b1, 1'b0, 32'h0000_0124, 32'h0);
    n = 0;
    while (!(line_wr_en && line_wr_idx == 4'd7) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("t4 at beat7", line_wr_idx, 7);
    rst = 1'b1;
    #1;
    check("t4 rst wr_en",   line_wr_en, 0);
    check("t4 rst idx",     line_wr_idx, 0);
    check("t4 rst data",    line_wr_data, 0);
    check("t4 rst busy",    cpu_busy, 0);
    check("t4 rst menable", mem_if.MEnable, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w1 = wr_cnt;
    repeat (20) @(negedge clk);
    check("t4 no done",        64'(done_cnt - d0), 64'd0);
    check("t4 beats pre rst",  64'(w1 - w0), 64'd7);
    check("t4 beats post rst", 64'(wr_cnt - w1), 64'd0);
    e0 = idx_err; w0 = wr_cnt;
    issue(1'b1, 1'b0, 32'h0000_0124, 32'h0);
    wait_done("t4 rd", 200);
    check("t4 idx seq", 64'(idx_err - e0), 64'd0);
    check("t4 beats",   64'(wr_cnt - w0), 64'd16);
    check("t4 beat0",   cap[0], 32'hA0);

    // Request held while memory is not ready
    tb_stall = 1'b1; m0 = men_cnt; r0 = mrd_cnt; w0 = wr_cnt;
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = 32'h0000_0124;
    repeat (5) @(negedge clk);
    check("t5 no menable", 64'(men_cnt - m0), 64'd0);
    check("t5 idle",       cpu_busy, 0);
    tb_stall = 1'b0;
    @(negedge clk);
    cpu_read = 1'b0;
    check("t5 accepted", cpu_busy, 1);
    wait_done("t5", 200);
    check("t5 one mread", 64'(mrd_cnt - r0), 64'd1);
    check("t5 beats",     64'(wr_cnt - w0), 64'd16);
    check("t5 beat5",     cap[5], 32'hA5);

`ifdef MEM_MASTER_TIMEOUT_EN
    // Memory never returns MReady
    mem_dead = 1'b1; w0 = wr_cnt;
    issue(1'b1, 1'b0, 32'h0000_0124, 32'h0);
    wait_done("t6", 200);
    check("t6 err",     err, 1);
    check("t6 latency", 64'(done_cyc - rreq_cyc), 64'(TIMEOUT + 1));
    check("t6 beats",   64'(wr_cnt - w0), 64'd0);
    check("t6 idle",    cpu_busy, 0);
    mem_dead = 1'b0;
    repeat (3) @(negedge clk);
`else
    check("err tied low", err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
